// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the seven-segment scan controller: BCD width, segment
// patterns (bit6=a ... bit0=g, active-high) and the scan FSM state type.
// No logic; imported by display_scan_ctrl and bcd7seg_decoder.
package display_scan_ctrl_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_decoder.sv
// Purpose: BCD to seven-segment decode; values 10..15 decode to blank.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
// Ports: bcd (4-bit value in), seg (7-bit active-high segments, bit6=a).
module bcd7seg_decoder
  import display_scan_ctrl_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [6:0]       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Purpose: time-multiplexed seven-segment scan with blanking gap and
//          double-buffered value (shadow -> active commit at frame end).
// Latency: outputs registered, one cycle behind the scan FSM; a load shows
//          between BLANK_CYCLES+1 cycles after the commit edge and one frame
//          plus BLANK_CYCLES+1 cycles. Backpressure: none, load always taken.
// Ports: clock, reset (sync, active-high), load/digits_in (packed BCD, digit 0
//        in [3:0]), segments (a..g), digit_en (one-hot), frame_done (pulse).
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits
// (digit 0 is never suppressed; digit_en still pulses).
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DWELL        = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [BCD_W*DIGITS-1:0]   digits_in,
  output logic [6:0]                segments,
  output logic [DIGITS-1:0]         digit_en,
  output logic                      frame_done
);

  localparam int IDX_W   = $clog2(DIGITS);
  localparam int CNT_MAX = max_int(DWELL, BLANK_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] EN_ONE    = DIGITS'(1);

  scan_state_t              state, state_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [IDX_W-1:0]         idx, idx_nxt;
  logic                     commit;
  logic [BCD_W*DIGITS-1:0]  shadow;
  logic [BCD_W*DIGITS-1:0]  active;
  logic                     pending;
  logic [BCD_W-1:0]         cur_bcd;
  logic [6:0]               dec_seg;
  logic                     suppress;

  // Scan FSM: BLANK for BLANK_CYCLES, then SHOW for DWELL, then next digit.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    commit    = 1'b0;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == DWELL_LAST) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = '0;
          if (idx == IDX_LAST) begin
            idx_nxt = '0;
            commit  = 1'b1;   // last digit done: frame boundary
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_BLANK;
      cnt     <= '0;
      idx     <= '0;
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      if (load) begin
        shadow <= digits_in;
      end
      // A load on the commit edge bypasses the shadow so it shows this frame.
      if (commit) begin
        if (load) begin
          active <= digits_in;
        end else if (pending) begin
          active <= shadow;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Single shared decoder behind the digit mux.
  assign cur_bcd = active[int'(idx)*BCD_W +: BCD_W];

  bcd7seg_decoder u_dec (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // Digit is a leading zero when it and every more significant digit is 0.
  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(idx)) && (active[j*BCD_W +: BCD_W] != '0)) begin
        upper_zero = 1'b0;
      end
    end
    suppress = (idx != '0) && upper_zero;
  end
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      segments   <= SEG_BLANK;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (state == ST_SHOW) begin
        segments <= suppress ? SEG_BLANK : dec_seg;
        digit_en <= EN_ONE << idx;
      end else begin
        segments <= SEG_BLANK;
        digit_en <= '0;
      end
      frame_done <= commit;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Purpose: randomized self-checking bench for display_scan_ctrl against a
//          time-arithmetic reference (slot/digit derived from edge count).
// Latency/backpressure: n/a. Honours LEADING_ZERO_BLANK_EN like the design.
module tb_display_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DWELL  = 4;
  localparam int BLANK  = 1;
  localparam int PER    = BLANK + DWELL;
  localparam int FRAME  = PER * DIGITS;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load  = 1'b0;
  logic [15:0] digits_in = '0;
  logic [6:0]  segments;
  logic [3:0]  digit_en;
  logic        frame_done;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: edges since reset release plus value buffers.
  int          k = 0;
  logic [15:0] m_active = '0;
  logic [15:0] m_shadow = '0;
  bit          m_pend   = 1'b0;

  display_scan_ctrl #(
    .DIGITS       (DIGITS),
    .DWELL        (DWELL),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .digits_in  (digits_in),
    .segments   (segments),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, k);
  endtask

  // One clock edge: compute what the outputs must be after it, apply, check.
  task automatic tick(input logic rst, input logic ld, input logic [15:0] din);
    logic [6:0]  e_seg;
    logic [3:0]  e_en;
    logic        e_fd;
    int          slot, di;
    bit          show, wrap;
    logic [15:0] upper;
    reset = rst; load = ld; digits_in = din;
    e_seg = '0; e_en = '0; e_fd = 1'b0;
    if (rst) begin
      k = 0; m_active = '0; m_shadow = '0; m_pend = 1'b0;
    end else begin
      slot = k % PER;
      di   = (k / PER) % DIGITS;
      show = (slot >= BLANK);
      wrap = ((k + 1) % FRAME) == 0;
      if (show) begin
        e_en  = 4'(1 << di);
        e_seg = seg_of(m_active[di*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        upper = m_active >> (4 * di);
        if (di != 0 && upper == 16'h0) e_seg = 7'b0000000;
`endif
      end
      e_fd = wrap;
      if (wrap) begin
        if (ld) m_active = din;
        else if (m_pend) m_active = m_shadow;
        m_pend = 1'b0;
      end else if (ld) begin
        m_pend = 1'b1;
      end
      if (ld) m_shadow = din;
      k++;
    end
    @(posedge clock);
    #1;
    chk("segments", 32'(segments), 32'(e_seg));
    chk("digit_en", 32'(digit_en), 32'(e_en));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("onehot", 32'($countones(digit_en) <= 1), 32'd1);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    int guard;
    // Reset with a load present: must be discarded.
    tick(1'b1, 1'b1, 16'hBEEF);
    tick(1'b1, 1'b0, 16'h0);
    // 1: first load waits for the frame boundary.
    tick(1'b0, 1'b1, 16'h1234);
    idle(45);
    // 2: two loads in one frame, last wins.
    tick(1'b0, 1'b1, 16'h0000);
    idle(3);
    tick(1'b0, 1'b1, 16'h5678);
    idle(45);
    // 3: load exactly on the commit edge.
    guard = 0;
    while (((k + 1) % FRAME) != 0 && guard < FRAME) begin
      tick(1'b0, 1'b0, 16'h0);
      guard++;
    end
    tick(1'b0, 1'b1, 16'h9999);
    idle(25);
    // 4: out-of-range digits decode blank.
    tick(1'b0, 1'b1, 16'hAF00);
    idle(45);
    tick(1'b0, 1'b1, 16'h0A3C);
    idle(45);
    // 5: reset mid-SHOW of digit 2 with a pending load.
    tick(1'b0, 1'b1, 16'h4321);
    guard = 0;
    while (!(((k / PER) % DIGITS) == 2 && (k % PER) == 2) && guard < FRAME) begin
      tick(1'b0, 1'b0, 16'h0);
      guard++;
    end
    tick(1'b1, 1'b1, 16'h7777);
    idle(45);
    // 6: leading-zero patterns.
    tick(1'b0, 1'b1, 16'h0070);
    idle(45);
    tick(1'b0, 1'b1, 16'h0000);
    idle(45);
    tick(1'b0, 1'b1, 16'h0105);
    idle(45);
    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(0, 3) == 0) v = v & 16'h0FFF;
      if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
      if ($urandom_range(0, 199) == 0)
        tick(1'b1, 1'($urandom_range(0, 1)), v);
      else
        tick(1'b0, ($urandom_range(0, 7) == 0), v);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
